// File: rtl/conv_pkg.sv
// conv_pkg: shared widths and FSM state type for the convolution write-back path
package conv_pkg;
  localparam int ADDR_W = 7;
  localparam int WORD_W = 32;
  localparam int MAC_W  = 12;
  localparam int BYTE_W = 8;
  localparam int CNT_W  = 8;
  typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} state_t;
endpackage

// File: rtl/wb_byte_packer.sv
// wb_byte_packer: reduces MAC results to bytes and packs them MSB-first into a word (CONV_WB_ROUND_EN selects rounding)
module wb_byte_packer
  import conv_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              push,
  input  logic [MAC_W-1:0]  data,
  output logic [WORD_W-1:0] word,
  output logic              full
);
  logic [1:0]        slot;
  logic [BYTE_W-1:0] b;
`ifdef CONV_WB_ROUND_EN
  logic [MAC_W:0] sum;
  assign sum = {1'b0, data} + (MAC_W+1)'(8);
  assign b   = sum[MAC_W] ? '1 : sum[MAC_W-1:4];
`else
  assign b = data[MAC_W-1:4];
`endif
  assign full = slot == 2'd3;
  // Word register starts zeroed so unfilled bytes of a partial word read as 0
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      word <= '0;
      slot <= '0;
    end else if (push) begin
      word[WORD_W-1-BYTE_W*slot -: BYTE_W] <= b;
      slot <= slot + 2'd1;
    end
  end
endmodule

// File: rtl/conv_writeback.sv
// conv_writeback: packs a job of MAC results into 32-bit words and writes them to memory (optional CONV_WB_ROUND_EN rounding)
module conv_writeback
  import conv_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  res_count,
  input  logic              res_valid,
  input  logic [MAC_W-1:0]  res_data,
  output logic              res_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  input  logic              mem_ack,
  output logic              busy,
  output logic              done
);
  state_t            state, state_n;
  logic [ADDR_W-1:0] addr;
  logic [CNT_W-1:0]  left;
  logic              push, full, clr, acked, go;
  assign go        = state == IDLE && start;
  assign push      = state == FILL && res_valid;
  assign acked     = state == WRITE && mem_ack;
  assign clr       = go || acked;
  assign res_ready = state == FILL;
  assign mem_we    = state == WRITE;
  assign busy      = state != IDLE;
  assign done      = state == DONE;
  assign mem_addr  = addr;
  wb_byte_packer u_packer (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .push (push),
    .data (res_data),
    .word (mem_wdata),
    .full (full)
  );
  // Next state: a word is flushed when full or when the job's last result lands
  always_comb begin
    state_n = state;
    case (state)
      IDLE:  if (start) state_n = res_count == '0 ? DONE : FILL;
      FILL:  if (push && (full || left == CNT_W'(1))) state_n = WRITE;
      WRITE: if (mem_ack) state_n = left == '0 ? DONE : FILL;
      DONE:  state_n = IDLE;
    endcase
  end
  // State, write address and remaining-result counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      addr  <= '0;
      left  <= '0;
    end else begin
      state <= state_n;
      if (go) begin
        addr <= base_addr;
        left <= res_count;
      end
      if (push) left <= left - CNT_W'(1);
      if (acked) addr <= addr + ADDR_W'(1);
    end
  end
endmodule

// File: doc/conv_writeback.md
CONV_WRITEBACK -- requirements
Module: conv_writeback

Interface
REQ-001 SHALL have port: clk  input  1  system clock, rising-edge.
REQ-002 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL have port: start  input  1  one-cycle pulse; begins a write-back job.
REQ-004 SHALL have port: base_addr  input  7  first memory word address, sampled on accepted start.
REQ-005 SHALL have port: res_count  input  8  number of results in job, sampled on accepted start.
REQ-006 SHALL have port: res_valid  input  1  result present on res_data.
REQ-007 SHALL have port: res_data  input  12  raw MAC accumulator result.
REQ-008 SHALL have port: res_ready  output  1  block accepts result this cycle.
REQ-009 SHALL have port: mem_we  output  1  write request to memory.
REQ-010 SHALL have port: mem_addr  output  7  write word address.
REQ-011 SHALL have port: mem_wdata  output  32  packed write data.
REQ-012 SHALL have port: mem_ack  input  1  memory accepted write this cycle.
REQ-013 SHALL have port: busy  output  1  job in progress.
REQ-014 SHALL have port: done  output  1  one-cycle pulse at job end.

Function
REQ-015 SHALL implement FSM states IDLE, FILL, WRITE, DONE.
REQ-016 IDLE: start=1 latches base_addr/res_count; res_count=0 -> DONE, else -> FILL; start outside IDLE SHALL be ignored.
REQ-017 FILL: res_ready=1; transfer occurs when res_valid & res_ready; other states res_ready=0.
REQ-018 Each transfer SHALL reduce res_data to 8 bits (see Configuration) and pack MSB-first: 1st byte [31:24], 2nd [23:16], 3rd [15:8], 4th [7:0].
REQ-019 FILL -> WRITE in the cycle after the 4th byte of a word or the job's last result is accepted; mem_we=1 in that next cycle.
REQ-020 Partial final word: unfilled bytes SHALL be 0.
REQ-021 WRITE: mem_we, mem_addr, mem_wdata SHALL stay stable until mem_ack=1; mem_ack in same cycle as first mem_we completes write.
REQ-022 On ack: mem_addr increments by 1 modulo 128 (127 -> 0 wrap, no error); byte slot clears; -> DONE if all results written, else -> FILL.
REQ-023 DONE: done=1 for exactly one cycle, then -> IDLE.
REQ-024 busy=1 in FILL, WRITE, DONE; 0 in IDLE.
REQ-025 mem_ack outside WRITE SHALL be ignored.
REQ-026 Words written per job SHALL equal ceil(res_count/4).

Reset
REQ-027 rst=1 SHALL force IDLE, regardless of state, and have priority over start.
REQ-028 On reset: res_ready, mem_we, busy, done =0; mem_addr=0; mem_wdata=0; byte slot and result counter =0.
REQ-029 Reset mid-job SHALL abandon the job; no further mem_we until a new start.

Configuration
REQ-030 Macro CONV_WB_ROUND_EN undefined: byte = res_data[11:4] (truncate).
REQ-031 Macro CONV_WB_ROUND_EN defined: byte = (res_data + 8) >> 4, saturated to 8'hFF when the sum exceeds 12 bits.

Structure
REQ-032 Shared package conv_pkg SHALL hold ADDR_W=7, WORD_W=32, MAC_W=12, BYTE_W=8 and the FSM state type.
REQ-033 Byte packing and reduction SHALL live in one sub-module wb_byte_packer (4x8 register, slot counter, zero fill); the FSM and address counter remain in conv_writeback.

Verification
REQ-034 base_addr=7'h10, res_count=4, data 12'h120,12'h340,12'h560,12'h780, ack immediate -> one write addr 7'h10, wdata 32'h12345678, done one cycle later.
REQ-035 res_count=6, base_addr=7'h7F, data 12'h010..12'h060 step 12'h010 -> writes {addr 7'h7F, 32'h01020304} then {addr 7'h00, 32'h05060000}.
REQ-036 Hold mem_ack=0 for 5 cycles -> mem_we/addr/wdata constant and res_ready=0 throughout; single write on ack.
REQ-037 start with res_count=0 -> no mem_we, busy high one cycle, done pulse next cycle; second start while busy ignored.
REQ-038 rst asserted in WRITE -> next cycle mem_we=0, busy=0, mem_addr=0; no write afterwards.
REQ-039 CONV_WB_ROUND_EN defined: res_data 12'h128 -> byte 8'h13; 12'hFFC -> 8'hFF; undefined: 12'h128 -> 8'h12.
